// File: rtl/dominos_rom_loader.sv
// Dominos ROM download router: splits the HPS byte stream into
// per-region ROM/PROM write strobes and gates the core run signal.
module dominos_rom_loader #(
  parameter int PROG_SIZE   = 4096,
  parameter int CHAR_SIZE   = 1024,
  parameter int SYNC_SIZE   = 256,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        Clk_I,
  input  logic        Reset_I,
  input  logic        Dl_I,
  input  logic        Wr_I,
  input  logic [24:0] Addr_I,
  input  logic [7:0]  Data_I,
  output logic [11:0] Wr_Addr_O,
  output logic [7:0]  Wr_Data_O,
  output logic        Prog_We_O,
  output logic        Char_We_O,
  output logic        Sync_We_O,
  output logic        Run_O,
  output logic        Busy_O,
  output logic        Err_O,
  output logic [13:0] Count_O,
  output logic [7:0]  Csum_O
);

  localparam logic [24:0] L_CHAR_BASE = 25'(PROG_SIZE);
  localparam logic [24:0] L_SYNC_BASE = 25'(PROG_SIZE + CHAR_SIZE);
  localparam logic [24:0] L_TOTAL =
    25'(PROG_SIZE + CHAR_SIZE + SYNC_SIZE);
  localparam logic [15:0] L_HOLD = 16'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic        r_dl_q;
  logic [15:0] r_hold;
  logic [11:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_prog_we;
  logic        r_char_we;
  logic        r_sync_we;
  logic        r_run;
  logic        r_busy;
  logic        r_err;
  logic [13:0] r_count;
  logic [7:0]  r_csum;

  logic        w_rise;
  logic        w_fall;
  logic        w_prog;
  logic        w_char;
  logic        w_sync;
  logic        w_open;
  logic        w_acc;
  logic [24:0] w_base;
  logic [24:0] w_diff;
  logic [13:0] w_cnt_base;
  logic [13:0] w_cnt_inc;
  logic [13:0] w_cnt_next;
  logic [7:0]  w_sum_next;

  assign w_rise = Dl_I & ~r_dl_q;
  assign w_fall = ~Dl_I & r_dl_q;

  assign w_prog = Addr_I < L_CHAR_BASE;
  assign w_char = ~w_prog & (Addr_I < L_SYNC_BASE);
  assign w_sync = ~w_prog & ~w_char & (Addr_I < L_TOTAL);

  // Bytes are taken through the whole LOAD state (its last cycle is
  // the Dl_I fall) and in the entry cycle itself.
  assign w_open = (r_state == S_LOAD) | w_rise;
  assign w_acc  = Wr_I & w_open & (Addr_I < L_TOTAL);

  // Region base select for the region-relative write address.
  always_comb begin
    w_base = '0;
    unique case (1'b1)
      w_prog:  w_base = '0;
      w_char:  w_base = L_CHAR_BASE;
      default: w_base = L_SYNC_BASE;
    endcase
  end

  assign w_diff = Addr_I - w_base;

  assign w_cnt_base = w_rise ? 14'd0 : r_count;
  assign w_cnt_inc  = (&w_cnt_base) ? w_cnt_base
                                    : w_cnt_base + 14'd1;
  assign w_cnt_next = w_acc ? w_cnt_inc : w_cnt_base;
  assign w_sum_next = (w_rise ? 8'd0 : r_csum)
                    + (w_acc ? Data_I : 8'd0);

  // Loader FSM with registered strobes, statistics and status.
  always_ff @(posedge Clk_I or negedge Reset_I) begin
    if (!Reset_I) begin
      r_state   <= S_IDLE;
      r_dl_q    <= 1'b1;
      r_hold    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_prog_we <= 1'b0;
      r_char_we <= 1'b0;
      r_sync_we <= 1'b0;
      r_run     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
      r_csum    <= '0;
    end else begin
      r_dl_q    <= Dl_I;
      r_prog_we <= w_acc & w_prog;
      r_char_we <= w_acc & w_char;
      r_sync_we <= w_acc & w_sync;
      if (w_acc) begin
        r_wr_addr <= w_diff[11:0];
        r_wr_data <= Data_I;
      end
      r_count <= w_cnt_next;
      r_csum  <= w_sum_next;
      r_run   <= (r_state == S_RUN);
      r_busy  <= (r_state == S_LOAD) | (r_state == S_SETTLE);
      r_err   <= (r_state == S_ERROR);
      if (w_rise) begin
        r_state <= S_LOAD;
      end else begin
        unique case (r_state)
          S_LOAD: begin
            if (w_fall) begin
              r_hold  <= L_HOLD;
              r_state <= ({11'd0, w_cnt_next} >= L_TOTAL)
                       ? S_SETTLE : S_ERROR;
            end
          end
          S_SETTLE: begin
            if (r_hold == 16'd0) r_state <= S_RUN;
            else r_hold <= r_hold - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign Wr_Addr_O = r_wr_addr;
  assign Wr_Data_O = r_wr_data;
  assign Prog_We_O = r_prog_we;
  assign Char_We_O = r_char_we;
  assign Sync_We_O = r_sync_we;
  assign Run_O     = r_run;
  assign Busy_O    = r_busy;
  assign Err_O     = r_err;
  assign Count_O   = r_count;
  assign Csum_O    = r_csum;

endmodule

// File: tb/tb_dominos_rom_loader.sv
// Bench for dominos_rom_loader: scoreboard of expected ROM writes
// plus an image-level model of count, checksum and release.
module tb_dominos_rom_loader;

  localparam int PROG  = 4096;
  localparam int CHR   = 1024;
  localparam int SYN   = 256;
  localparam int TOTAL = PROG + CHR + SYN;

  logic        Clk_I;
  logic        Reset_I;
  logic        Dl_I;
  logic        Wr_I;
  logic [24:0] Addr_I;
  logic [7:0]  Data_I;
  logic [11:0] Wr_Addr_O;
  logic [7:0]  Wr_Data_O;
  logic        Prog_We_O;
  logic        Char_We_O;
  logic        Sync_We_O;
  logic        Run_O;
  logic        Busy_O;
  logic        Err_O;
  logic [13:0] Count_O;
  logic [7:0]  Csum_O;

  dominos_rom_loader dut (
    .Clk_I     (Clk_I),
    .Reset_I   (Reset_I),
    .Dl_I      (Dl_I),
    .Wr_I      (Wr_I),
    .Addr_I    (Addr_I),
    .Data_I    (Data_I),
    .Wr_Addr_O (Wr_Addr_O),
    .Wr_Data_O (Wr_Data_O),
    .Prog_We_O (Prog_We_O),
    .Char_We_O (Char_We_O),
    .Sync_We_O (Sync_We_O),
    .Run_O     (Run_O),
    .Busy_O    (Busy_O),
    .Err_O     (Err_O),
    .Count_O   (Count_O),
    .Csum_O    (Csum_O)
  );

  initial Clk_I = 1'b0;
  always #5 Clk_I = ~Clk_I;

  typedef struct {
    int r;
    int a;
    int d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   np, nc, ns;
  bit   m_dl;
  bit   m_loading;
  int   m_cnt;
  int   m_sum;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next
  // expected write from the model.
  always @(negedge Clk_I) begin
    int n;
    int r;
    exp_t e;
    if (Reset_I) begin
      n = int'(Prog_We_O) + int'(Char_We_O) + int'(Sync_We_O);
      if (n > 1) chk("we_onehot", n, 1);
      if (n > 0) begin
        r = Prog_We_O ? 0 : (Char_We_O ? 1 : 2);
        if (r == 0) np++;
        else if (r == 1) nc++;
        else ns++;
        if (q.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          e = q.pop_front();
          chk("we_region", r, e.r);
          chk("we_addr", int'(Wr_Addr_O), e.a);
          chk("we_data", int'(Wr_Data_O), e.d);
        end
      end
    end
  end

  // One clock of stimulus; the model decides what the loader accepts.
  task automatic cyc(bit dl, bit wr, logic [24:0] a, logic [7:0] d);
    int ai;
    bit rise;
    bit fall;
    rise = dl && !m_dl;
    fall = !dl && m_dl;
    Dl_I   = dl;
    Wr_I   = wr;
    Addr_I = a;
    Data_I = d;
    if (rise) begin
      m_loading = 1'b1;
      m_cnt = 0;
      m_sum = 0;
    end
    if (wr && m_loading && a < 25'(TOTAL)) begin
      ai = int'(a);
      if (ai < PROG) q.push_back('{0, ai, int'(d)});
      else if (ai < PROG + CHR) q.push_back('{1, ai - PROG, int'(d)});
      else q.push_back('{2, ai - PROG - CHR, int'(d)});
      if (m_cnt < 16383) m_cnt++;
      m_sum = (m_sum + int'(d)) % 256;
    end
    if (fall) m_loading = 1'b0;
    m_dl = dl;
    @(posedge Clk_I);
    #1;
  endtask

  task automatic download(int n, bit first_rise, bit last_fall,
                          bit rnd, bit oob);
    int i;
    logic [7:0] d;
    np = 0;
    nc = 0;
    ns = 0;
    i = 0;
    if (first_rise) begin
      d = rnd ? 8'($urandom) : 8'd0;
      cyc(1'b1, 1'b1, 25'd0, d);
      i = 1;
    end else begin
      cyc(1'b1, 1'b0, 25'd0, 8'd0);
    end
    while (i < n - int'(last_fall)) begin
      if (rnd && $urandom_range(0, 7) == 0)
        cyc(1'b1, 1'b0, 25'($urandom), 8'($urandom));
      if (oob && $urandom_range(0, 15) == 0)
        cyc(1'b1, 1'b1,
            ($urandom_range(0, 1) == 1) ? 25'd5376 : 25'h1FFFFFF,
            8'($urandom));
      d = rnd ? 8'($urandom) : 8'(i);
      cyc(1'b1, 1'b1, 25'(i), d);
      i++;
    end
    if (last_fall) begin
      d = rnd ? 8'($urandom) : 8'(n - 1);
      cyc(1'b0, 1'b1, 25'(n - 1), d);
    end else begin
      cyc(1'b0, 1'b0, 25'd0, 8'd0);
    end
  endtask

  // Called right after the edge that samples Dl_I low.
  task automatic check_release();
    for (int k = 1; k <= 17; k++) begin
      @(posedge Clk_I);
      #1;
      chk($sformatf("run_edge%0d", k), int'(Run_O), int'(k == 17));
    end
  endtask

  task automatic check_stats(string tag);
    chk({tag, "_count"}, int'(Count_O), m_cnt);
    chk({tag, "_csum"}, int'(Csum_O), m_sum);
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_run"}, int'(Run_O), 0);
    chk({tag, "_busy"}, int'(Busy_O), 0);
    chk({tag, "_err"}, int'(Err_O), 0);
    chk({tag, "_we"},
        int'({Prog_We_O, Char_We_O, Sync_We_O}), 0);
    chk({tag, "_waddr"}, int'(Wr_Addr_O), 0);
    chk({tag, "_wdata"}, int'(Wr_Data_O), 0);
    chk({tag, "_count"}, int'(Count_O), 0);
    chk({tag, "_csum"}, int'(Csum_O), 0);
  endtask

  initial begin
    int saved;
    bit saw_run;
    Reset_I = 1'b0;
    Dl_I = 1'b0;
    Wr_I = 1'b0;
    Addr_I = '0;
    Data_I = '0;
    m_dl = 1'b0;
    m_loading = 1'b0;
    m_cnt = 0;
    m_sum = 0;
    repeat (3) @(posedge Clk_I);
    #1;
    check_reset_vals("rst");
    Reset_I = 1'b1;
    cyc(1'b0, 1'b0, 25'd0, 8'd0);

    // Full ordered image, data = addr[7:0].
    download(TOTAL, 1'b0, 1'b0, 1'b0, 1'b0);
    check_release();
    chk("full_prog_we", np, PROG);
    chk("full_char_we", nc, CHR);
    chk("full_sync_we", ns, SYN);
    chk("full_err", int'(Err_O), 0);
    check_stats("full");

    // Strobes while not downloading.
    saved = m_cnt;
    for (int k = 0; k < 6; k++)
      cyc(1'b0, 1'b1, 25'($urandom_range(0, TOTAL - 1)),
          8'($urandom));
    chk("idle_count", int'(Count_O), saved);
    chk("idle_run", int'(Run_O), 1);

    // Short random image.
    download(5000, 1'b0, 1'b0, 1'b1, 1'b1);
    saw_run = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge Clk_I);
      #1;
      if (Run_O) saw_run = 1'b1;
    end
    chk("short_run_low", int'(saw_run), 0);
    chk("short_err", int'(Err_O), 1);
    chk("short_busy", int'(Busy_O), 0);
    check_stats("short");

    // Full random image with bytes on the rise and fall cycles.
    download(TOTAL, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("edge_err_cleared", int'(Err_O), 0);
    check_release();
    chk("edge_err", int'(Err_O), 0);
    chk("edge_count_total", int'(Count_O), TOTAL);
    check_stats("edge");

    // Re-download from RUN, then abandon it empty.
    cyc(1'b1, 1'b0, 25'd0, 8'd0);
    cyc(1'b1, 1'b0, 25'd0, 8'd0);
    chk("redl_run", int'(Run_O), 0);
    chk("redl_busy", int'(Busy_O), 1);
    chk("redl_count", int'(Count_O), 0);
    chk("redl_csum", int'(Csum_O), 0);
    cyc(1'b0, 1'b0, 25'd0, 8'd0);
    cyc(1'b0, 1'b0, 25'd0, 8'd0);
    cyc(1'b0, 1'b0, 25'd0, 8'd0);
    chk("redl_err", int'(Err_O), 1);

    // Reset in the middle of a load.
    cyc(1'b1, 1'b0, 25'd0, 8'd0);
    for (int k = 0; k < 100; k++)
      cyc(1'b1, 1'b1, 25'(k), 8'($urandom));
    Reset_I = 1'b0;
    q.delete();
    m_loading = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(posedge Clk_I);
    #1;
    Reset_I = 1'b1;
    for (int k = 0; k < 5; k++)
      cyc(1'b1, 1'b1, 25'($urandom_range(0, TOTAL - 1)),
          8'($urandom));
    chk("postrst_count", int'(Count_O), 0);
    chk("postrst_busy", int'(Busy_O), 0);
    cyc(1'b0, 1'b0, 25'd0, 8'd0);
    download(TOTAL, 1'b0, 1'b0, 1'b1, 1'b0);
    check_release();
    check_stats("final");
    repeat (2) @(posedge Clk_I);
    #1;
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
